// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
//  Module   : control_seq
//  Purpose  : Multi-cycle RV32I instruction sequencer. Steps each instruction
//             through FETCH, DECODE, EXEC, optional MEM and WB, waits on the
//             memory ready handshake with an optional timeout, and parks in
//             HALT on a fault until reset.
//  Options  : define CONTROL_TRAP_EN to trap unlisted opcodes into HALT and
//             expose the sticky illegal_o flag. Without it, unlisted opcodes
//             retire as NOPs.
//  Revision : 1.0 - initial release
// ============================================================================
module control_seq #(
  parameter int MEM_TIMEOUT = 0,  // max wait cycles in FETCH/MEM, 0 = unlimited
  parameter int WB_MERGE    = 0   // 1: non-memory instructions retire in EXEC
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output logic [2:0] step_o,
  output logic       fetch_o,
  output logic       mem_re_o,
  output logic       mem_we_o,
  output logic       ir_we_o,
  output logic       reg_re1_o,
  output logic       reg_re2_o,
  output logic       reg_we_o,
  output logic       pc_enable_o,
  output logic       halted_o,
`ifdef CONTROL_TRAP_EN
  output logic       illegal_o,
`endif
  output logic       bus_err_o
);

  // State codes double as the externally visible step number.
  localparam logic [2:0] C_FETCH  = 3'd0;
  localparam logic [2:0] C_DECODE = 3'd1;
  localparam logic [2:0] C_EXEC   = 3'd2;
  localparam logic [2:0] C_MEM    = 3'd3;
  localparam logic [2:0] C_WB     = 3'd4;
  localparam logic [2:0] C_HALT   = 3'd7;

  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;

  // Wait counter only needs to reach MEM_TIMEOUT-1; keep at least one bit so
  // the timeout-disabled build still has a legal vector.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_TO_LAST =
    CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic w_is_load;
  logic w_is_store;
  logic w_is_mem;
  logic w_writes_rd;
  logic w_waiting;
  logic w_timeout;
  logic w_trap;

  assign w_is_load  = (opcode_i == C_OP_LOAD);
  assign w_is_store = (opcode_i == C_OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;

  // Decode which listed opcodes write the register file; also marks legality.
  logic w_listed;
  always_comb begin
    w_writes_rd = 1'b0;
    w_listed    = 1'b0;
    case (opcode_i)
      C_OP_IMM, C_OP_OP, C_OP_LUI, C_OP_AUIPC,
      C_OP_LOAD, C_OP_JAL, C_OP_JALR: begin
        w_writes_rd = 1'b1;
        w_listed    = 1'b1;
      end
      C_OP_STORE, C_OP_BRANCH: begin
        w_listed    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CONTROL_TRAP_EN
  assign w_trap = ~w_listed;
`else
  // Unlisted opcodes fall through as NOPs, so legality is not consulted.
  logic w_unused_listed;
  assign w_unused_listed = w_listed;
  assign w_trap          = 1'b0;
`endif

  // A wait cycle is any FETCH/MEM cycle without the memory acknowledging.
  assign w_waiting = ((state_q == C_FETCH) || (state_q == C_MEM)) && !mem_ready_i;
  // The handshake wins: a ready in the last allowed cycle is not a timeout.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (cnt_q == C_TO_LAST);

  // Wait counter runs only while waiting, so it is zero on every entry into
  // FETCH or MEM.
  assign cnt_d     = w_waiting ? (cnt_q + CNT_W'(1)) : '0;
  assign bus_err_d = bus_err_q | w_timeout;

  // State register plus wait counter and sticky fault flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= C_FETCH;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef CONTROL_TRAP_EN
  logic illegal_q;
  // Sticky illegal-opcode flag, set as EXEC traps into HALT.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      illegal_q <= 1'b0;
    end else if ((state_q == C_EXEC) && w_trap) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal_o = illegal_q;
`endif

  // Next-state selection per phase and opcode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_FETCH: begin
        if (mem_ready_i)    state_d = C_DECODE;
        else if (w_timeout) state_d = C_HALT;
      end
      C_DECODE: state_d = C_EXEC;
      C_EXEC: begin
        if (w_is_mem)           state_d = C_MEM;
        else if (w_trap)        state_d = C_HALT;
        else if (WB_MERGE != 0) state_d = C_FETCH;
        else                    state_d = C_WB;
      end
      C_MEM: begin
        if (mem_ready_i)    state_d = C_WB;
        else if (w_timeout) state_d = C_HALT;
      end
      C_WB:    state_d = C_FETCH;
      C_HALT:  state_d = C_HALT;
      default: state_d = C_FETCH;
    endcase
  end

  // Strobes decoded from the current phase; all suppressed during reset.
  always_comb begin
    fetch_o     = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    ir_we_o     = 1'b0;
    reg_re1_o   = 1'b0;
    reg_re2_o   = 1'b0;
    reg_we_o    = 1'b0;
    pc_enable_o = 1'b0;
    if (!reset_i) begin
      case (state_q)
        C_FETCH: begin
          fetch_o  = 1'b1;
          mem_re_o = 1'b1;
          ir_we_o  = mem_ready_i;
        end
        C_DECODE: begin
          reg_re1_o = 1'b1;
          reg_re2_o = 1'b1;
        end
        C_EXEC: begin
          if ((WB_MERGE != 0) && !w_is_mem && !w_trap) begin
            pc_enable_o = 1'b1;
            reg_we_o    = w_writes_rd;
          end
        end
        C_MEM: begin
          mem_re_o = w_is_load;
          mem_we_o = w_is_store;
        end
        C_WB: begin
          pc_enable_o = 1'b1;
          reg_we_o    = w_writes_rd;
        end
        default: ;
      endcase
    end
  end

  assign step_o    = state_q;
  assign halted_o  = (state_q == C_HALT);
  assign bus_err_o = bus_err_q;

endmodule
`default_nettype wire

// File: doc/control_seq.md
# control_seq

Multi-cycle instruction sequencer for the RV32I core. It replaces the fixed four-step counter with a per-opcode state machine. The sequence is FETCH, DECODE, EXEC, optional MEM, then WB. Memory phases wait on a ready handshake with an optional timeout, and the sequencer can enter a halt state on a fault. It sits between the instruction register (its `opcode` source) and the PC, register-file and memory-port enables.

## Interface
- `MEM_TIMEOUT`, default 0: maximum consecutive wait cycles on `mem_ready` in FETCH or MEM. A value of 0 disables the timeout.
- `WB_MERGE`, default 0: when 1, non-memory instructions retire in EXEC and skip WB.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instr[6:0] from the IR. Valid from DECODE onward; ignored in FETCH.
- `mem_ready`  in  1  memory acknowledges the current read or write this cycle.
- `step`  out  3  state code: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- `fetch`  out  1  memory address select = PC (high in FETCH).
- `mem_re`  out  1  memory read request.
- `mem_we`  out  1  memory write request.
- `ir_we`  out  1  latch instruction into the IR.
- `reg_re1`, `reg_re2`  out  1 each  register-file read enables.
- `reg_we`  out  1  register-file write enable.
- `pc_enable`  out  1  PC update strobe (PC+4 or branch/jump target, selected elsewhere).
- `halted`  out  1  state is HALT.
- `bus_err`  out  1  sticky flag: HALT was entered by timeout.
- `illegal`  out  1  sticky flag: HALT was entered by illegal opcode. Present only with `CONTROL_TRAP_EN`.

## Operation
- **State register and outputs.**
  - The state is a registered 3-bit value. All strobes are combinational functions of the state, `opcode` and `mem_ready`.
  - While `reset` is high, every strobe is forced to 0.
  - On the reset edge: state becomes FETCH, `bus_err`=0, `illegal`=0, wait counter=0.
- **FETCH**
  - Asserts `fetch` and `mem_re`.
  - When `mem_ready`=1: asserts `ir_we` in the same cycle, next state is DECODE.
  - Otherwise stays in FETCH.
- **DECODE**
  - Asserts `reg_re1` and `reg_re2`. Next state is EXEC.
- **EXEC**
  - LOAD (0000011) or STORE (0100011): next state is MEM.
  - Legal non-memory opcode: next state is WB. With `WB_MERGE`=1, the WB strobes are asserted here instead and the next state is FETCH.
  - Legal opcode set: OP_IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, BRANCH 1100011, JAL 1101111, JALR 1100111, LOAD, STORE.
- **MEM**
  - LOAD asserts `mem_re`; STORE asserts `mem_we`.
  - Stays in MEM until `mem_ready`=1, then goes to WB. Memory instructions always pass through WB, regardless of `WB_MERGE`.
- **WB**
  - Asserts `pc_enable`.
  - `reg_we`=1 for OP_IMM, OP, LUI, AUIPC, LOAD, JAL and JALR; 0 for STORE and BRANCH.
  - Next state is FETCH.
- **HALT**
  - All strobes are 0 and `halted`=1. The block leaves HALT only on reset.
- **Wait counter**
  - Width is $clog2(MEM_TIMEOUT+1), with a minimum of 1.
  - Cleared on every transition into FETCH or MEM.
  - Increments each cycle spent in FETCH or MEM with `mem_ready`=0.
  - If `MEM_TIMEOUT`≠0 and the counter equals `MEM_TIMEOUT`-1 while `mem_ready`=0: next state is HALT and `bus_err` is set.
  - If `mem_ready`=1 in that same cycle, the handshake completes normally; the handshake wins.
- **Reset mid-operation:** any state, including MEM with a request outstanding, returns to FETCH. No strobe is issued in the reset cycle.

## Timing
- Zero-wait memory, cycles per instruction:
  - ALU, branch and jump: 4 cycles (FETCH, DECODE, EXEC, WB); 3 cycles with `WB_MERGE`=1.
  - LOAD and STORE: 5 cycles.
- Each cycle of `mem_ready`=0 adds one cycle to FETCH or MEM.
- Exactly one `pc_enable` pulse per retired instruction. None for a halted instruction.
- `ir_we` and `reg_we` are single-cycle pulses.
- `mem_re` and `mem_we` are held until the `mem_ready` cycle inclusive and are never asserted together.
- `step` changes only on the clock edge.

## Configuration
- **`CONTROL_TRAP_EN` defined**
  - An unlisted opcode in EXEC sends the next state to HALT and sets `illegal`.
  - No `pc_enable` and no `reg_we` for that instruction.
- **`CONTROL_TRAP_EN` undefined**
  - An unlisted opcode is a NOP: it goes to WB (or retires in EXEC when `WB_MERGE`=1) with `pc_enable`=1 and `reg_we`=0.
  - The `illegal` port is absent.

## Test plan
- **Zero-wait OP_IMM:** reset, then hold opcode 0010011 with `mem_ready`=1 → `step` sequence 0,1,2,4,0. `ir_we` in cycle 0; `reg_re1`/`reg_re2` in cycle 1; `reg_we` and `pc_enable` in cycle 3.
- **Fetch wait with timeout disabled:** `mem_ready` low for 3 cycles, then high, opcode 0110011 → FETCH lasts 4 cycles, `ir_we` only in the 4th, total 7 cycles to `pc_enable`.
- **LOAD and STORE:**
  - LOAD with 2 MEM wait cycles → `mem_re` held 3 cycles in MEM, then WB with `reg_we`=1.
  - STORE → `mem_we` in MEM, then WB with `reg_we`=0 and `pc_enable`=1.
- **Timeout:** `MEM_TIMEOUT`=4 and `mem_ready` stuck low in FETCH → HALT after 4 FETCH cycles, `bus_err`=1, `step`=7, no strobes afterwards; reset clears both flags.
  - Repeat with `mem_ready`=1 exactly on the 4th cycle → DECODE, no halt.
- **`WB_MERGE`=1:** JAL → 3-cycle instruction with `reg_we` and `pc_enable` in EXEC. LOAD still takes 5 cycles.
- **Illegal opcode 1111111:**
  - With `CONTROL_TRAP_EN` → HALT, `illegal`=1, no `pc_enable`.
  - Without it → `pc_enable`=1, `reg_we`=0, back to FETCH.
  - Also assert reset in MEM mid-wait → next cycle `step`=0, no `mem_we`.
